// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with load-use bubbles and ALU operand forwarding
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_op,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic [RA_W-1:0]   exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [RA_W-1:0]   memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [RA_W-1:0]   ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    logic [RA_W-1:0]   ex_rs1;
    logic [RA_W-1:0]   ex_rs2;
    logic [DATA_W-1:0] ex_rs1_val;
    logic [DATA_W-1:0] ex_rs2_val;
    logic [DATA_W-1:0] ex_imm;
    logic              ex_use_imm;

    logic lu;
    logic wb_hit1;
    logic wb_hit2;
    logic [DATA_W-1:0] fwd_rs1;
    logic [DATA_W-1:0] fwd_rs2;

    assign lu = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign id_stall = ex_stall | lu;

    // The register file is written at the end of WB, so its read port is one cycle stale.
    assign wb_hit1 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs1);
    assign wb_hit2 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            alu_opcode   <= 4'b0000;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_imm       <= '0;
            ex_use_imm   <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (ex_stall) begin
            ex_valid <= ex_valid;
        end else if (flush || lu) begin
            ex_valid     <= 1'b0;
            alu_opcode   <= 4'b0000;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_imm       <= '0;
            ex_use_imm   <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            alu_opcode   <= id_alu_op;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_rs1_val   <= wb_hit1 ? memwb_result : id_rs1_data;
            ex_rs2_val   <= wb_hit2 ? memwb_result : id_rs2_data;
            ex_imm       <= id_imm;
            ex_use_imm   <= id_use_imm;
            ex_reg_write <= id_reg_write & id_valid;
            ex_mem_read  <= id_mem_read & id_valid;
            ex_mem_write <= id_mem_write & id_valid;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
    always_comb begin
        fwd_rs1 = ex_rs1_val;
        if (ex_valid && exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs1))
            fwd_rs1 = exmem_result;
        else if (ex_valid && memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs1))
            fwd_rs1 = memwb_result;
    end

    always_comb begin
        fwd_rs2 = ex_rs2_val;
        if (ex_valid && exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs2))
            fwd_rs2 = exmem_result;
        else if (ex_valid && memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs2))
            fwd_rs2 = memwb_result;
    end

    assign alu_in1       = fwd_rs1;
    assign alu_in2       = ex_use_imm ? ex_imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_alu_op;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm, id_reg_write, id_mem_read, id_mem_write;
    logic        flush, ex_stall;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic        id_stall, ex_valid;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    id_ex_operand_stage #(.DATA_W(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .ex_stall(ex_stall),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .id_stall(id_stall), .ex_valid(ex_valid), .alu_opcode(alu_opcode),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    // Instruction currently sitting in EX, as the model believes it to be.
    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2, imm;
        logic        use_imm, rw, mr, mw;
    } ex_t;

    ex_t m, m_next;
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] stored);
        if (!m.valid) return stored;
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
        return stored;
    endfunction

    function automatic logic model_lu();
        return m.valid && m.mr && m.rd != 0 && id_valid &&
               ((id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd));
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] rs, input logic [31:0] data);
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
        return data;
    endfunction

    // Compare at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            chk("id_stall", {31'b0, id_stall}, {31'b0, ex_stall | model_lu()});
            chk("ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
            chk("ex_ctrl", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write}, {29'b0, m.rw, m.mr, m.mw});
            chk("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
            if (m.valid) begin
                chk("alu_opcode", {28'b0, alu_opcode}, {28'b0, m.op});
                chk("alu_in1", alu_in1, fwd(m.rs1, m.v1));
                chk("alu_in2", alu_in2, m.use_imm ? m.imm : fwd(m.rs2, m.v2));
                chk("store_data", ex_store_data, fwd(m.rs2, m.v2));
            end
        end
        m_next = m;
        if (ex_stall) m_next = m;
        else if (flush || model_lu()) m_next = '0;
        else begin
            m_next.valid   = id_valid;
            m_next.op      = id_alu_op;
            m_next.rs1     = id_rs1;
            m_next.rs2     = id_rs2;
            m_next.rd      = id_rd;
            m_next.v1      = rf_read(id_rs1, id_rs1_data);
            m_next.v2      = rf_read(id_rs2, id_rs2_data);
            m_next.imm     = id_imm;
            m_next.use_imm = id_use_imm;
            m_next.rw      = id_reg_write & id_valid;
            m_next.mr      = id_mem_read & id_valid;
            m_next.mw      = id_mem_write & id_valid;
        end
        @(posedge clk);
        m = rst_n ? m_next : '0;
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_alu_op = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_use_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        flush = 0; ex_stall = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
    endtask

    task automatic randomize_inputs();
        id_valid     = ($urandom_range(0, 7) != 0);
        id_alu_op    = 4'($urandom_range(0, 15));
        id_rs1       = 5'($urandom_range(0, 7));
        id_rs2       = 5'($urandom_range(0, 7));
        id_rd        = 5'($urandom_range(0, 7));
        id_uses_rs1  = 1'($urandom);
        id_uses_rs2  = 1'($urandom);
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_imm       = $urandom;
        id_use_imm   = 1'($urandom);
        id_reg_write = 1'($urandom);
        id_mem_read  = ($urandom_range(0, 2) == 0);
        id_mem_write = ($urandom_range(0, 3) == 0);
        flush        = ($urandom_range(0, 7) == 0);
        ex_stall     = ($urandom_range(0, 7) == 0);
        exmem_rd        = 5'($urandom_range(0, 7));
        exmem_reg_write = 1'($urandom);
        exmem_result    = $urandom;
        memwb_rd        = 5'($urandom_range(0, 7));
        memwb_reg_write = 1'($urandom);
        memwb_result    = $urandom;
    endtask

    initial begin
        m = '0;
        rst_n = 1'b0;
        randomize_inputs();
        #3;
        chk("reset_valid", {31'b0, ex_valid}, 32'd0);
        chk("reset_opcode", {28'b0, alu_opcode}, 32'd0);
        chk("reset_in1", alu_in1, 32'd0);
        chk("reset_in2", alu_in2, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m = '0;
        clear_inputs();

        // Plain ADD r3 = r1 + r2
        id_valid = 1; id_alu_op = 4'b0010; id_rs1 = 1; id_rs2 = 2; id_rd = 3;
        id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1_data = 5; id_rs2_data = 7; id_reg_write = 1;
        tick();
        chk("add_opcode", {28'b0, alu_opcode}, 32'h2);
        chk("add_in1", alu_in1, 32'd5);
        chk("add_in2", alu_in2, 32'd7);
        chk("add_rd", {27'b0, ex_rd}, 32'd3);
        chk("add_rw", {31'b0, ex_reg_write}, 32'd1);

        // Forwarding priority on rs1 = r4
        id_rs1 = 4; id_rs1_data = 32'h99;
        tick();
        exmem_rd = 4; exmem_reg_write = 1; exmem_result = 32'h10;
        memwb_rd = 4; memwb_reg_write = 1; memwb_result = 32'h20;
        #1 chk("fwd_exmem_first", alu_in1, 32'h10);
        exmem_reg_write = 0;
        #1 chk("fwd_memwb", alu_in1, 32'h20);
        clear_inputs();
        id_valid = 1; id_alu_op = 4'b0010; id_rs1 = 0; id_rs1_data = 32'h55; id_uses_rs1 = 1; id_rd = 3;
        tick();
        exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'h10;
        memwb_rd = 0; memwb_reg_write = 1; memwb_result = 32'h20;
        #1 chk("fwd_r0_never", alu_in1, 32'h55);

        // Load-use: LW r6, then SUB r7 = r6 - r1
        clear_inputs();
        id_valid = 1; id_alu_op = 4'b0010; id_rs1 = 2; id_rd = 6; id_uses_rs1 = 1;
        id_use_imm = 1; id_reg_write = 1; id_mem_read = 1;
        tick();
        clear_inputs();
        id_valid = 1; id_alu_op = 4'b0110; id_rs1 = 6; id_rs2 = 1; id_rd = 7;
        id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1_data = 32'hDEAD; id_rs2_data = 32'h3; id_reg_write = 1;
        #1 chk("lu_stall", {31'b0, id_stall}, 32'd1);
        tick();
        chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
        chk("lu_stall_once", {31'b0, id_stall}, 32'd0);
        tick();
        memwb_rd = 6; memwb_reg_write = 1; memwb_result = 32'h1234;
        #1;
        chk("lu_sub_valid", {31'b0, ex_valid}, 32'd1);
        chk("lu_sub_in1", alu_in1, 32'h1234);
        chk("lu_sub_opcode", {28'b0, alu_opcode}, 32'h6);

        // Flush during stall is ignored; flush alone bubbles
        memwb_reg_write = 0;
        flush = 1; ex_stall = 1;
        tick();
        chk("flush_stall_valid", {31'b0, ex_valid}, 32'd1);
        chk("flush_stall_rd", {27'b0, ex_rd}, 32'd7);
        ex_stall = 0;
        tick();
        chk("flush_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_rw", {31'b0, ex_reg_write}, 32'd0);

        // Store with immediate address and forwarded store data
        clear_inputs();
        id_valid = 1; id_alu_op = 4'b0010; id_rs1 = 2; id_rs2 = 5; id_uses_rs1 = 1; id_uses_rs2 = 1;
        id_use_imm = 1; id_imm = 32'hFFFF_FFFC; id_mem_write = 1; id_rs2_data = 32'h1;
        tick();
        exmem_rd = 5; exmem_reg_write = 1; exmem_result = 32'hABCD;
        #1;
        chk("sw_in2", alu_in2, 32'hFFFF_FFFC);
        chk("sw_store", ex_store_data, 32'hABCD);
        chk("sw_mw", {31'b0, ex_mem_write}, 32'd1);

        for (int i = 0; i < 500; i++) begin
            randomize_inputs();
            tick();
        end

        // Asynchronous reset mid-operation
        id_valid = 1; flush = 0; ex_stall = 0; id_reg_write = 1;
        tick();
        #1 rst_n = 1'b0;
        m = '0;
        #1;
        chk("async_valid", {31'b0, ex_valid}, 32'd0);
        chk("async_rw", {31'b0, ex_reg_write}, 32'd0);
        chk("async_in1", alu_in1, 32'd0);
        chk("async_in2", alu_in2, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            randomize_inputs();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage; sits directly upstream of the EX-stage ALU.
- Captures decoded instruction fields each cycle and inserts bubbles on load-use hazards or flush.
- Holds its contents on downstream stall.
- Drives ALU opcode and both ALU operands, resolving EX/MEM and MEM/WB forwarding combinationally.

Parameters:
- DATA_W, 32, datapath width
- RA_W, 5, register address width; register 0 is hardwired zero

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_alu_op  in  4  ALU opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- id_rs1, id_rs2, id_rd  in  RA_W  source and destination register numbers
- id_uses_rs1, id_uses_rs2  in  1  instruction reads rs1 / rs2
- id_rs1_data, id_rs2_data  in  DATA_W  register-file read values
- id_imm  in  DATA_W  sign-extended immediate
- id_use_imm  in  1  operand B = immediate
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- flush  in  1  squash the instruction entering EX (taken branch)
- ex_stall  in  1  downstream not accepting; hold stage
- exmem_rd  in  RA_W, exmem_reg_write  in  1, exmem_result  in  DATA_W  EX/MEM forwarding source
- memwb_rd  in  RA_W, memwb_reg_write  in  1, memwb_result  in  DATA_W  MEM/WB forwarding source
- id_stall  out  1  decode must hold its instruction this cycle
- ex_valid  out  1  EX instruction valid
- alu_opcode  out  4  to ALU
- alu_in1, alu_in2  out  DATA_W  to ALU
- ex_store_data  out  DATA_W  forwarded rs2 value for stores
- ex_rd  out  RA_W; ex_reg_write, ex_mem_read, ex_mem_write  out  1  control passed to EX/MEM

Behaviour:
- Reset (async, rst_n=0): all registered fields are 0. ex_valid=0, alu_opcode=0000, all control bits 0, ex_rd=0, and the stored operands are 0.
- Reset mid-operation discards the held instruction. The first edge after release behaves as a normal update.
- Hazard signal `lu`:
  - lu = ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)) & id_valid.
- id_stall = ex_stall | lu (combinational).
- Register update priority at each rising edge:
  1. ex_stall=1: hold all registers unchanged; flush is ignored (the issuer keeps flush asserted).
  2. flush=1: load a bubble. Bubble = ex_valid=0, all control bits 0, alu_opcode 0000, ex_rd 0.
  3. lu=1: load a bubble. The ID instruction is held and re-presented by decode next cycle.
  4. Otherwise load the ID fields. The loaded ex_valid equals id_valid; when id_valid=0, control bits are loaded as 0.
- WB write-through at capture: the stored rs1 value is memwb_result when memwb_reg_write & memwb_rd!=0 & memwb_rd==id_rs1; otherwise it is id_rs1_data. The stored rs2 value follows the same rule.
- Forwarding (combinational from registered sources), per operand X in {rs1, rs2}:
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rsX, use exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rsX, use memwb_result.
  - Else use the stored value.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
  - No forwarding occurs when ex_valid=0.
- Outputs:
  - alu_in1 = fwd_rs1.
  - alu_in2 = ex_use_imm ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2, always, independent of use_imm.
- Latency: one cycle from ID capture to EX outputs. Throughput is one instruction per cycle with no hazards.
- A load-use hazard costs exactly one bubble. The following cycle takes the loaded value through MEM/WB forwarding.
- Flush and lu in the same cycle produce a single bubble.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs -> ex_valid=0, alu_opcode=0000, alu_in1=alu_in2=0; outputs change asynchronously on rst_n fall.
- Plain ADD: ADD r3=r1+r2 with rs1_data=5, rs2_data=7 and no forwarding -> next cycle alu_opcode=0010, alu_in1=5, alu_in2=7, ex_rd=3, ex_reg_write=1.
- Forwarding priority: EX holds rs1=4; exmem_rd=4 (result 0x10) and memwb_rd=4 (result 0x20) both writing -> alu_in1=0x10. With exmem_reg_write=0 -> alu_in1=0x20. With rs1=0 and both sources targeting r0 -> alu_in1 equals the stored value.
- Load-use: LW r6 in EX followed by SUB r7=r6-r1 in ID -> id_stall=1 for 1 cycle and a bubble (ex_valid=0) enters. Next cycle the SUB enters with memwb_rd=6 supplying alu_in1.
- Flush vs stall: flush=1 & ex_stall=1 -> EX contents unchanged. Then flush=1 & ex_stall=0 -> ex_valid=0, ex_reg_write=0.
- Immediate/store: SW with use_imm=1, imm=0xFFFFFFFC, rs2 forwarded from exmem=0xABCD -> alu_in2=0xFFFFFFFC, ex_store_data=0xABCD, ex_mem_write=1.
